ssd_phone_sequencer: RTL and testbench



---
 rtl/ssd_seq_pkg.sv | 19 +
 rtl/ssd_phone_sequencer_tick_prescaler.sv | 37 +++
 rtl/ssd_phone_sequencer.sv | 151 +++++++++++++++
 tb/tb_ssd_phone_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_seq_pkg.sv
// Shared types and sizing helpers for the phone-number SSD digit sequencer.
package ssd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int SEL_W = 3;

    // Tick counter must hold the largest phase length minus one.
    function automatic int tick_cnt_w(input int show_ticks, input int gap_ticks);
        int m;
        m = (show_ticks > gap_ticks) ? show_ticks : gap_ticks;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/ssd_phone_sequencer_tick_prescaler.sv
// Free-running divider producing one tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick must not depend on clr: the caller derives clr from tick.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ssd_phone_sequencer.sv
// Walks the SSD digit selector through all positions with a show phase and an optional blank gap per digit.
module ssd_phone_sequencer
    import ssd_seq_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int SHOW_TICKS = 2,
    parameter int GAP_TICKS  = 1,
    parameter int NUM_DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             loop_en,
    output logic [SEL_W-1:0] selector_out,
    output logic             ssd_enable,
    output logic             busy,
    output logic             done
);

    localparam int TW = tick_cnt_w(SHOW_TICKS, GAP_TICKS);
    localparam logic [TW-1:0]    SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0]    GAP_LAST  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             pre_clr;
    logic             digit_end;
    logic             tick;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (!pause),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tcnt_d    = tcnt_q;
        pre_clr   = 1'b0;
        digit_end = 1'b0;

        unique case (state_q)
            IDLE: begin
                pre_clr = 1'b1;
                tcnt_d  = '0;
                sel_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                if (start && !abort) begin
                    state_d = SHOW;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHOW: begin
                if (!pause && tick) begin
                    if (tcnt_q == SHOW_LAST) begin
                        tcnt_d  = '0;
                        pre_clr = 1'b1;
                        if (GAP_TICKS > 0) begin
                            state_d = GAP;
                            en_d    = 1'b0;
                        end else begin
                            digit_end = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!pause && tick) begin
                    if (tcnt_q == GAP_LAST) begin
                        tcnt_d    = '0;
                        pre_clr   = 1'b1;
                        digit_end = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (digit_end) begin
            if (sel_q < SEL_LAST) begin
                sel_d   = sel_q + 1'b1;
                state_d = SHOW;
                en_d    = 1'b1;
            end else if (loop_en) begin
                sel_d   = '0;
                state_d = SHOW;
                en_d    = 1'b1;
            end else begin
                sel_d   = '0;
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        // Abort overrides everything, including a completing pass.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            sel_d   = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            tcnt_d  = '0;
            pre_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign selector_out = sel_q;
    assign ssd_enable   = en_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ssd_phone_sequencer.sv
// Directed bench for the SSD digit sequencer: default build plus a no-gap four-digit build.
module tb_ssd_phone_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, pause, loop_en;
    logic [2:0] sel1;
    logic       en1, busy1, done1;
    logic       start2;
    logic [2:0] sel2;
    logic       en2, busy2, done2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ssd_phone_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .loop_en      (loop_en),
        .selector_out (sel1),
        .ssd_enable   (en1),
        .busy         (busy1),
        .done         (done1)
    );

    ssd_phone_sequencer #(
        .TICK_DIV   (4),
        .SHOW_TICKS (2),
        .GAP_TICKS  (0),
        .NUM_DIGITS (4)
    ) dut_nogap (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start2),
        .abort        (1'b0),
        .pause        (1'b0),
        .loop_en      (1'b0),
        .selector_out (sel2),
        .ssd_enable   (en2),
        .busy         (busy2),
        .done         (done2)
    );

    // Output word packing: {selector, enable, busy, done}
    function automatic logic [5:0] obs1();
        return {sel1, en1, busy1, done1};
    endfunction

    function automatic logic [5:0] obs2();
        return {sel2, en2, busy2, done2};
    endfunction

    // Default build: p is the count of active (unpaused) cycles since start; 12 cycles per digit.
    function automatic logic [5:0] exp1(input int p, input bit lp);
        int d, pos;
        logic [2:0] s;
        if (p < 1) return 6'd0;
        if (!lp && p == 97) return 6'b000_0_0_1;
        if (!lp && p > 97) return 6'd0;
        d   = ((p - 1) / 12) % 8;
        pos = (p - 1) % 12;
        s   = d[2:0];
        return {s, (pos < 8), 1'b1, 1'b0};
    endfunction

    // No-gap build: 8 cycles per digit, 4 digits, done at cycle 33.
    function automatic logic [5:0] exp2(input int p);
        int d;
        logic [2:0] s;
        if (p < 1 || p > 33) return 6'd0;
        if (p == 33) return 6'b000_0_0_1;
        d = (p - 1) / 8;
        s = d[2:0];
        return {s, 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got sel/en/busy/done=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        int held;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; loop_en = 1'b0; start2 = 1'b0;
        step(); step();
        chk("reset", obs1(), 6'd0);
        chk("reset_nogap", obs2(), 6'd0);
        rst_n = 1'b1;
        step();
        chk("idle", obs1(), 6'd0);

        // Full non-looping pass
        start = 1'b1;
        step();
        start = 1'b0;
        p = 1;
        chk("pass_first", obs1(), exp1(p, 1'b0));
        while (p < 99) begin
            step();
            p++;
            chk($sformatf("pass_c%0d", p), obs1(), exp1(p, 1'b0));
        end

        // Looping pass: sel wraps to 0, done never pulses
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        p = 1;
        chk("loop_first", obs1(), exp1(p, 1'b1));
        while (p < 120) begin
            step();
            p++;
            chk($sformatf("loop_c%0d", p), obs1(), exp1(p, 1'b1));
        end
        loop_en = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("loop_abort", obs1(), 6'd0);

        // Pause for 10 cycles in sel=3 SHOW; start pulsed while busy is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        p = 1;
        held = 0;
        chk("pause_first", obs1(), exp1(p, 1'b0));
        while (p < 98) begin
            if (p == 40 && held < 10) begin
                pause = 1'b1;
                held++;
            end else begin
                pause = 1'b0;
            end
            start = (held == 5) ? 1'b1 : 1'b0;
            step();
            if (!pause) p++;
            chk($sformatf("pause_p%0d", p), obs1(), exp1(p, 1'b0));
        end
        pause = 1'b0;
        start = 1'b0;

        // Abort in GAP of sel=5, then restart
        start = 1'b1;
        step();
        start = 1'b0;
        p = 1;
        while (p < 70) begin
            step();
            p++;
        end
        chk("abort_in_gap", obs1(), exp1(70, 1'b0));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_next", obs1(), 6'd0);
        step();
        chk("abort_no_done", obs1(), 6'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart", obs1(), exp1(1, 1'b0));
        for (int i = 2; i <= 14; i++) begin
            step();
            chk($sformatf("restart_c%0d", i), obs1(), exp1(i, 1'b0));
        end
        abort = 1'b1;
        step();
        chk("abort2", obs1(), 6'd0);

        // abort and start together in IDLE: stay idle
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", obs1(), 6'd0);

        // pause does not block start in IDLE; abort beats pause
        pause = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pause_idle_start", obs1(), exp1(1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("paused_hold", obs1(), exp1(1, 1'b0));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        pause = 1'b0;
        chk("abort_over_pause", obs1(), 6'd0);

        // Reset mid-sequence with start held high
        start = 1'b1;
        step();
        start = 1'b0;
        p = 1;
        while (p < 20) begin
            step();
            p++;
        end
        chk("pre_reset", obs1(), exp1(20, 1'b0));
        rst_n = 1'b0;
        start = 1'b1;
        step();
        chk("mid_reset", obs1(), 6'd0);
        step();
        chk("reset_start_held", obs1(), 6'd0);
        rst_n = 1'b1;
        step();
        start = 1'b0;
        chk("post_reset_start", obs1(), exp1(1, 1'b0));
        for (int i = 2; i <= 14; i++) begin
            step();
            chk($sformatf("post_reset_c%0d", i), obs1(), exp1(i, 1'b0));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("post_reset_abort", obs1(), 6'd0);

        // No-gap, four-digit build
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        p = 1;
        chk("nogap_first", obs2(), exp2(p));
        while (p < 35) begin
            step();
            p++;
            chk($sformatf("nogap_c%0d", p), obs2(), exp2(p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
